// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round controller.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int ROUND_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ_KEY,
        ISSUE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/aes_ctrl_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags when LIMIT is reached.
// expire is combinational from the count register only, so it never loops back through clr.
module aes_ctrl_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle holding LAST is the LIMIT-th enabled cycle since the clear.
    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps rounds 0..NR, fetching each key and issuing one AddRoundKey.
// Optional stall watchdog (abort + err pulse) enabled by macro AES_CTRL_TIMEOUT_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR          = NR_AES128,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic               abort,
    output logic               key_req,
    output logic [ROUND_W-1:0] key_round,
    input  logic               key_valid,
    output logic               ark_data_valid,
    output logic               ark_key_valid,
    input  logic               ark_valid_out,
    output logic [ROUND_W-1:0] round_idx,
    output logic               sel_input,
    output logic               skip_mix,
    output logic               done_valid,
    input  logic               done_ready,
    output logic               busy,
    output logic               err
);

    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NR);

    if (NR < 1 || NR >= (1 << ROUND_W) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("aes_round_ctrl: NR or TIMEOUT_CYC out of range");
    end

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               expire;

`ifdef AES_CTRL_TIMEOUT_EN
    logic err_q, err_d;

    aes_ctrl_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_d != state_q),
        .en     ((state_q == REQ_KEY) || (state_q == WAIT)),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
`ifdef AES_CTRL_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = REQ_KEY;
                    round_d = '0;
                end
            end
            REQ_KEY: begin
                if (key_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ark_valid_out) begin
                    if (round_q == LAST_RND) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ_KEY;
                        round_d = round_q + ROUND_W'(1);
                    end
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase

        // Cancellation (external or watchdog) overrides every normal transition.
        if ((state_q != IDLE) && (abort || expire)) begin
            state_d = IDLE;
            round_d = '0;
`ifdef AES_CTRL_TIMEOUT_EN
            err_d   = expire;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
`ifdef AES_CTRL_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
`ifdef AES_CTRL_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign start_ready    = (state_q == IDLE);
    assign key_req        = (state_q == REQ_KEY);
    assign key_round      = round_q;
    assign ark_data_valid = (state_q == ISSUE);
    assign ark_key_valid  = (state_q == ISSUE);
    assign round_idx      = round_q;
    assign sel_input      = ((state_q == REQ_KEY) || (state_q == ISSUE) || (state_q == WAIT))
                            && (round_q == '0);
    assign skip_mix       = (round_q == LAST_RND);
    assign done_valid     = (state_q == DONE);
    assign busy           = (state_q != IDLE);

`ifdef AES_CTRL_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: phase-level reference model plus directed cycle checks.
module tb_aes_round_ctrl;

    localparam int NR          = 10;
    localparam int TIMEOUT_CYC = 16;

    localparam int S_IDLE  = 0;
    localparam int S_KEY   = 1;
    localparam int S_ISSUE = 2;
    localparam int S_WAIT  = 3;
    localparam int S_DONE  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_valid = 1'b0;
    logic       abort = 1'b0;
    logic       key_valid = 1'b0;
    logic       ark_valid_out = 1'b0;
    logic       done_ready = 1'b1;
    logic       start_ready, key_req, ark_data_valid, ark_key_valid;
    logic       sel_input, skip_mix, done_valid, busy, err;
    logic [3:0] key_round, round_idx;

    aes_round_ctrl #(
        .NR          (NR),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .abort          (abort),
        .key_req        (key_req),
        .key_round      (key_round),
        .key_valid      (key_valid),
        .ark_data_valid (ark_data_valid),
        .ark_key_valid  (ark_key_valid),
        .ark_valid_out  (ark_valid_out),
        .round_idx      (round_idx),
        .sel_input      (sel_input),
        .skip_mix       (skip_mix),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc - t0, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: phase and round of the sequencer, advanced once per clock.
    int m_st, m_rnd, m_age;
    bit m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = S_IDLE; m_rnd = 0; m_age = 0; m_err = 0;
        end else begin : upd
            int nst, nrnd;
            bit expire;
            nst = m_st; nrnd = m_rnd; expire = 0;
`ifdef AES_CTRL_TIMEOUT_EN
            expire = (m_st == S_KEY || m_st == S_WAIT) && (m_age + 1 >= TIMEOUT_CYC);
`endif
            if (m_st != S_IDLE && (abort || expire)) begin
                nst = S_IDLE; nrnd = 0;
            end else if (m_st == S_IDLE && start_valid) begin
                nst = S_KEY; nrnd = 0;
            end else if (m_st == S_KEY && key_valid) begin
                nst = S_ISSUE;
            end else if (m_st == S_ISSUE) begin
                nst = S_WAIT;
            end else if (m_st == S_WAIT && ark_valid_out) begin
                if (m_rnd == NR) nst = S_DONE;
                else begin nst = S_KEY; nrnd = m_rnd + 1; end
            end else if (m_st == S_DONE && done_ready) begin
                nst = S_IDLE; nrnd = 0;
            end
            m_err = expire;
            m_age = (nst == m_st) ? m_age + 1 : 0;
            m_st  = nst;
            m_rnd = nrnd;
        end
    end

    function automatic logic [16:0] exp_vec(input int st, input int rnd, input bit e);
        logic [3:0] r;
        r = 4'(rnd);
        return {st == S_IDLE, st == S_KEY, r, st == S_ISSUE, st == S_ISSUE, r,
                (st != S_IDLE && st != S_DONE && rnd == 0), rnd == NR, st == S_DONE,
                st != S_IDLE, e};
    endfunction

    wire [16:0] act_vec = {start_ready, key_req, key_round, ark_data_valid, ark_key_valid,
                           round_idx, sel_input, skip_mix, done_valid, busy, err};

    always @(negedge clk) begin
        if (chk_en) check("outputs_vs_model", 32'(act_vec), 32'(exp_vec(m_st, m_rnd, m_err)));
    end

    // Stimulus responders: key source and an AddRoundKey stand-in.
    int  ark_mode = 0;   // 0 echo 1-cycle, 1 random, 2 never, 3 stuck high
    int  key_mode = 0;   // 0 ready unless stalling round 3, 1 random
    int  stall_left = 0;
    bit  ark_prev = 0;

    always @(negedge clk) ark_prev = ark_data_valid;

    always @(posedge clk) begin
        #1;
        case (ark_mode)
            0: ark_valid_out = ark_prev;
            1: ark_valid_out = ($urandom_range(2) == 0);
            2: ark_valid_out = 1'b0;
            default: ark_valid_out = 1'b1;
        endcase
        if (key_mode == 1) begin
            key_valid = ($urandom_range(1) == 1);
        end else if (key_req && key_round == 4'd3 && stall_left > 0) begin
            key_valid = 1'b0;
            stall_left--;
        end else begin
            key_valid = 1'b1;
        end
    end

    // Per-block trace of issue pulses.
    bit mon_on = 0;
    int pulse_cyc[$];
    int pulse_rnd[$];
    int pulse_skip[$];
    int kr3 = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (ark_data_valid) begin
                pulse_cyc.push_back(cyc - t0);
                pulse_rnd.push_back(int'(round_idx));
                pulse_skip.push_back(int'(skip_mix));
            end
            if (key_req && key_round == 4'd3) kr3++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block();
        tick();
        check("start_ready_in_idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        t0 = cyc;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic run_block(input int budget, output int done_at);
        done_at = -1;
        for (int i = 0; i < budget && done_at < 0; i++) begin
            tick();
            if (done_valid) done_at = cyc - t0;
        end
    endtask

    task automatic clear_trace();
        pulse_cyc.delete(); pulse_rnd.delete(); pulse_skip.delete(); kr3 = 0;
    endtask

    int done_at;
    int err_seen;
    int ndone;

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1;
        check("reset_outputs", 32'(act_vec), 32'h10000);
        tick();
        reset = 1'b0;
        tick();

        // Best case: 11 issues every third cycle, done in cycle 34.
        clear_trace(); mon_on = 1;
        start_block();
        run_block(60, done_at);
        check("t1_done_cycle", 32'(done_at), 32'd34);
        check("t1_pulse_count", 32'(pulse_cyc.size()), 32'(NR + 1));
        for (int r = 0; r < pulse_cyc.size() && r <= NR; r++) begin
            check("t1_pulse_cycle", 32'(pulse_cyc[r]), 32'(2 + 3 * r));
            check("t1_pulse_round", 32'(pulse_rnd[r]), 32'(r));
            check("t1_pulse_skip", 32'(pulse_skip[r]), 32'(r == NR));
        end
        tick();

        // Key stall of 4 cycles in round 3.
        clear_trace(); stall_left = 4;
        start_block();
        run_block(70, done_at);
        check("t2_done_cycle", 32'(done_at), 32'd38);
        check("t2_pulse_count", 32'(pulse_cyc.size()), 32'(NR + 1));
        check("t2_keyreq_r3_cycles", 32'(kr3), 32'd5);
        if (pulse_cyc.size() > 4) begin
            check("t2_r3_issue", 32'(pulse_cyc[3]), 32'd15);
            check("t2_r4_issue", 32'(pulse_cyc[4]), 32'd18);
        end
        mon_on = 0;
        tick();

        // Consumer holds off 5 cycles while a new start is offered.
        done_ready = 1'b0;
        start_block();
        run_block(60, done_at);
        check("t3_done_cycle", 32'(done_at), 32'd34);
        for (int i = 0; i < 5; i++) begin
            check("t3_done_held", 32'(done_valid), 32'd1);
            check("t3_start_blocked", 32'(start_ready), 32'd0);
            start_valid = 1'b1;
            tick();
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        tick();
        check("t3_idle_after_ready", 32'({start_ready, busy, done_valid}), 32'b100);

        // Abort in WAIT of round 6, then a clean full block.
        start_block();
        while (cyc - t0 < 21) tick();
        check("t4_round_before_abort", 32'(round_idx), 32'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_after_abort", 32'({busy, round_idx, done_valid}), 32'd0);
        tick();
        start_block();
        run_block(60, done_at);
        check("t4_rerun_done_cycle", 32'(done_at), 32'd34);
        tick();

        // Reset in ISSUE of round 2; stuck-high ark_valid_out afterwards.
        start_block();
        while (cyc - t0 < 8) tick();
        check("t5_in_issue_r2", 32'({ark_data_valid, round_idx}), 32'h12);
        reset = 1'b1;
        #1;
        check("t5_reset_immediate", 32'(act_vec), 32'h10000);
        tick();
        reset = 1'b0;
        ark_mode = 3;
        repeat (4) tick();
        check("t5_spurious_ignored", 32'({busy, round_idx}), 32'd0);
        ark_mode = 0;
        tick();

        // Completion never returns in round 1.
        start_block();
        for (int i = 0; i < 20 && round_idx != 4'd1; i++) tick();
        check("t6_round1_reached", 32'(round_idx), 32'd1);
        ark_mode = 2;
        err_seen = 0;
        for (int i = 0; i < TIMEOUT_CYC + 10; i++) begin
            tick();
            if (err) err_seen++;
        end
`ifdef AES_CTRL_TIMEOUT_EN
        check("t6_err_pulses", 32'(err_seen), 32'd1);
        check("t6_idle_after_timeout", 32'(busy), 32'd0);
`else
        check("t6_err_pulses", 32'(err_seen), 32'd0);
        check("t6_still_waiting", 32'({busy, round_idx, key_req}), 32'b1_0001_0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_recovers", 32'(busy), 32'd0);
`endif

        // Random traffic against the model.
        key_mode = 1;
        ark_mode = 1;
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            start_valid = ($urandom_range(1) == 1);
            done_ready  = ($urandom_range(1) == 1);
            abort       = ($urandom_range(59) == 0);
            if (done_valid && done_ready && !abort) ndone++;
        end
        check("rand_blocks_completed", 32'(ndone > 0), 32'd1);
        start_valid = 1'b0;
        abort = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
